// File: rtl/kt_display_pkg.sv
// Shared constants and helpers for the kitchen-timer display path.
// Covers digit count, nibble width, blanking codes and the leading-zero test.
package kt_display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int NIBBLE_W   = 4;
  localparam int VALUE_W    = NUM_DIGITS * NIBBLE_W;

  localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 4'b1111;
  localparam logic [6:0]            SEG_BLANK  = 7'b1111111;

  // A slot is a leading zero when it and every more-significant nibble are 0.
  // Slot 0 never qualifies, so a value of zero still shows a single "0".
  function automatic logic leading_zero(input logic [VALUE_W-1:0] v,
                                        input logic [1:0]         slot);
    logic lz;
    lz = 1'b0;
    case (slot)
      2'd0:    lz = 1'b0;
      2'd1:    lz = (v[15:4]  == 12'h000);
      2'd2:    lz = (v[15:8]  == 8'h00);
      2'd3:    lz = (v[15:12] == 4'h0);
      default: lz = 1'b0;
    endcase
    return lz;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and raises tick on the last count.
// Runs independently of display enable.
module scan_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_r;

  assign tick = (cnt_r == CW'(DIV - 1));

  // Prescaler counter, wraps to zero on tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scan driver for a 4-digit common-anode display.
// Snapshots value/dp_in once per frame and drives one registered digit slot per tick.
module seven_seg_scanner
  import kt_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  enable,
  output logic [NIBBLE_W-1:0]   digit,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp_n,
  output logic                  blank,
  output logic                  frame_start
);

  logic                  tick_s;
  logic                  snap_s;
  logic [1:0]            idx_r, idx_next_s;
  logic [VALUE_W-1:0]    shadow_r, shadow_next_s;
  logic [NUM_DIGITS-1:0] shadow_dp_r, shadow_dp_next_s;
  logic                  valid_r, valid_next_s;
  logic                  lz_s;
  logic                  blank_next_s;
  logic [NIBBLE_W-1:0]   digit_next_s;
  logic                  dp_n_next_s;
  logic [NUM_DIGITS-1:0] an_next_s;

  scan_tick_gen #(.DIV(REFRESH_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  // Next slot, snapshot and output values; outputs look at post-edge state so
  // anode, digit and blank all switch together. valid keeps the display dark
  // until the first snapshot after reset.
  always_comb begin
    snap_s           = tick_s && (idx_r == 2'd3);
    idx_next_s       = idx_r;
    shadow_next_s    = shadow_r;
    shadow_dp_next_s = shadow_dp_r;
    valid_next_s     = valid_r | snap_s;
    if (tick_s) begin
      idx_next_s = idx_r + 2'd1;
    end else begin
      idx_next_s = idx_r;
    end
    if (snap_s) begin
      shadow_next_s    = value;
      shadow_dp_next_s = dp_in;
    end else begin
      shadow_next_s    = shadow_r;
      shadow_dp_next_s = shadow_dp_r;
    end
    lz_s         = LZ_BLANK && leading_zero(shadow_next_s, idx_next_s);
    blank_next_s = ~enable | ~valid_next_s | lz_s;
    digit_next_s = shadow_next_s[idx_next_s*NIBBLE_W +: NIBBLE_W];
    dp_n_next_s  = ~shadow_dp_next_s[idx_next_s];
    if (blank_next_s) begin
      an_next_s = ANODES_OFF;
    end else begin
      an_next_s = ~(4'b0001 << idx_next_s);
    end
  end

  // Slot index, snapshot registers and registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r       <= 2'd0;
      shadow_r    <= '0;
      shadow_dp_r <= '0;
      valid_r     <= 1'b0;
      an          <= ANODES_OFF;
      digit       <= 4'h0;
      dp_n        <= 1'b1;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      idx_r       <= idx_next_s;
      shadow_r    <= shadow_next_s;
      shadow_dp_r <= shadow_dp_next_s;
      valid_r     <= valid_next_s;
      an          <= an_next_s;
      digit       <= digit_next_s;
      dp_n        <= dp_n_next_s;
      blank       <= blank_next_s;
      frame_start <= snap_s;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner with REFRESH_DIV=4 (16-cycle frame).
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        enable;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        dp_n;
  logic        blank;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       en;
    logic [3:0] an;
    logic [3:0] digit;
    logic       dp_n;
    logic       blank;
    logic       fs;
  } exp_t;

  exp_t sb[$];

  seven_seg_scanner #(.REFRESH_DIV(4), .LZ_BLANK(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .dp_in       (dp_in),
    .enable      (enable),
    .digit       (digit),
    .an          (an),
    .dp_n        (dp_n),
    .blank       (blank),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // At most one anode may be low at any time.
  always @(negedge clk) begin
    n_checks++;
    if ($countones(~an) > 1) begin
      n_fail++;
      $display("FAIL onehot t=%0t an=%b required at most one low bit", $time, an);
    end
  end

  task automatic push_dark(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e = '{en: 1'b1, an: 4'b1111, digit: 4'h0, dp_n: 1'b1, blank: 1'b1, fs: 1'b0};
      sb.push_back(e);
    end
  endtask

  // Expected outputs for the first n edges of a frame, starting at frame_start.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] dp,
                            input logic [15:0] en_mask, input int n);
    exp_t e;
    int   i;
    logic lz;
    for (int k = 0; k < n; k++) begin
      i       = k / 4;
      lz      = (i != 0) && ((v >> (4 * i)) == 16'h0000);
      e.en    = en_mask[k];
      e.blank = !en_mask[k] || lz;
      e.digit = v[4*i +: 4];
      e.dp_n  = !dp[i];
      e.an    = e.blank ? 4'b1111 : ~(4'b0001 << i);
      e.fs    = (k == 0);
      sb.push_back(e);
    end
  endtask

  // Pop one expectation, apply its enable, and advance past one rising edge.
  task automatic step(output exp_t e);
    e = sb.pop_front();
    enable = e.en;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; value = 16'h1234; dp_in = 4'b0000; enable = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({an, digit, dp_n, blank, frame_start} !== {4'b1111, 4'h0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset an=%b digit=%h dp_n=%b blank=%b fs=%b required 1111 0 1 1 0",
               an, digit, dp_n, blank, frame_start);
    end
    rst = 1'b0;
  endtask

  task automatic test_scan;
    exp_t e;
    push_dark(15);
    push_frame(16'h1234, 4'b0000, 16'hFFFF, 16);
    for (int j = 0; j < 31; j++) begin
      step(e);
      n_checks++;
      if ({an, digit, dp_n, blank, frame_start} !== {e.an, e.digit, e.dp_n, e.blank, e.fs}) begin
        n_fail++;
        $display("FAIL scan j=%0d got an=%b digit=%h dp_n=%b blank=%b fs=%b required an=%b digit=%h dp_n=%b blank=%b fs=%b",
                 j, an, digit, dp_n, blank, frame_start, e.an, e.digit, e.dp_n, e.blank, e.fs);
      end
    end
  endtask

  task automatic test_leading_zero;
    exp_t e;
    logic [15:0] vals [2];
    vals[0] = 16'h0042;
    vals[1] = 16'h0000;
    for (int p = 0; p < 2; p++) begin
      value = vals[p];
      push_frame(vals[p], 4'b0000, 16'hFFFF, 16);
      for (int j = 0; j < 16; j++) begin
        step(e);
        n_checks++;
        if ({an, digit, dp_n, blank, frame_start} !== {e.an, e.digit, e.dp_n, e.blank, e.fs}) begin
          n_fail++;
          $display("FAIL lz v=%h j=%0d got an=%b digit=%h blank=%b fs=%b required an=%b digit=%h blank=%b fs=%b",
                   vals[p], j, an, digit, blank, frame_start, e.an, e.digit, e.blank, e.fs);
        end
      end
    end
  endtask

  task automatic test_snapshot;
    exp_t e;
    value = 16'h1234;
    push_frame(16'h1234, 4'b0000, 16'hFFFF, 16);
    push_frame(16'h5678, 4'b0000, 16'hFFFF, 16);
    for (int j = 0; j < 32; j++) begin
      if (j == 6) value = 16'h5678;
      step(e);
      n_checks++;
      if ({an, digit, dp_n, blank, frame_start} !== {e.an, e.digit, e.dp_n, e.blank, e.fs}) begin
        n_fail++;
        $display("FAIL snapshot j=%0d got an=%b digit=%h fs=%b required an=%b digit=%h fs=%b",
                 j, an, digit, frame_start, e.an, e.digit, e.fs);
      end
    end
  endtask

  task automatic test_dp_enable;
    exp_t e;
    dp_in = 4'b0100;
    push_frame(16'h5678, 4'b0100, 16'hFFFF, 16);
    push_frame(16'h5678, 4'b0100, 16'hFF8F, 16);
    for (int j = 0; j < 32; j++) begin
      step(e);
      n_checks++;
      if ({an, digit, dp_n, blank, frame_start} !== {e.an, e.digit, e.dp_n, e.blank, e.fs}) begin
        n_fail++;
        $display("FAIL dp_enable j=%0d got an=%b digit=%h dp_n=%b blank=%b required an=%b digit=%h dp_n=%b blank=%b",
                 j, an, digit, dp_n, blank, e.an, e.digit, e.dp_n, e.blank);
      end
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    push_frame(16'h5678, 4'b0100, 16'hFFFF, 9);
    for (int j = 0; j < 9; j++) begin
      step(e);
      n_checks++;
      if ({an, digit, dp_n, blank} !== {e.an, e.digit, e.dp_n, e.blank}) begin
        n_fail++;
        $display("FAIL pre_reset j=%0d got an=%b digit=%h required an=%b digit=%h",
                 j, an, digit, e.an, e.digit);
      end
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({an, digit, blank, dp_n, frame_start} !== {4'b1111, 4'h0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset got an=%b digit=%h blank=%b dp_n=%b fs=%b required 1111 0 1 1 0",
               an, digit, blank, dp_n, frame_start);
    end
    @(negedge clk);
    rst = 1'b0;
    push_dark(15);
    push_frame(16'h5678, 4'b0100, 16'hFFFF, 16);
    for (int j = 0; j < 31; j++) begin
      step(e);
      n_checks++;
      if ({an, digit, dp_n, blank, frame_start} !== {e.an, e.digit, e.dp_n, e.blank, e.fs}) begin
        n_fail++;
        $display("FAIL post_reset j=%0d got an=%b digit=%h dp_n=%b blank=%b fs=%b required an=%b digit=%h dp_n=%b blank=%b fs=%b",
                 j, an, digit, dp_n, blank, frame_start, e.an, e.digit, e.dp_n, e.blank, e.fs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_leading_zero();
    test_snapshot();
    test_dp_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not complete within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
